// File: rtl/spi_peripheral_tx.sv
// SPI mode-0 transmit-only peripheral: one-byte holding register feeding a shift
// register, 0x00 fill on underrun, and abort detection on early chip-select release.
module spi_peripheral_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SCLK,
    input  logic       spi_cs_n,
    output logic       CIPO,
    output logic       cipo_oe,
    input  logic       tx_enable,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_underrun,
    output logic       tx_abort
);

    localparam logic [1:0] TX_IDLE     = 2'd0;
    localparam logic [1:0] TX_SHIFT    = 2'd1;
    localparam logic [1:0] TX_BOUNDARY = 2'd2;

    logic       sclk_meta;
    logic       sclk_sync;
    logic       sclk_prev;
    logic       cs_meta;
    logic       cs_sync;
    logic       cs_prev;

    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;
    logic       cs_rise;

    logic [1:0] state;
    logic [7:0] hold_reg;
    logic       hold_full;
    logic [7:0] shift_reg;
    logic [3:0] bit_cnt;

    logic       accept;
    logic       load_req;
    logic       load_take;
    logic       mid_byte;

    // Chip select idles high and SCLK idles low, so the synchronizers reset to
    // those levels and never report a spurious edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= spi_cs_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
        end
    end

    assign sclk_rise = sclk_sync && !sclk_prev;
    assign sclk_fall = !sclk_sync && sclk_prev;
    assign cs_fall   = !cs_sync && cs_prev;
    assign cs_rise   = cs_sync && !cs_prev;

    assign tx_ready  = !hold_full && tx_enable;
    assign accept    = tx_valid && tx_ready;
    assign load_take = tx_enable && hold_full;
    assign mid_byte  = (bit_cnt != 4'd0) && !bit_cnt[3];

    // A byte boundary is the frame start or the SCLK fall after the 8th bit;
    // a chip-select release in the same cycle wins over it.
    always_comb begin
        load_req = 1'b0;
        if (!cs_rise) begin
            case (state)
                TX_IDLE:     load_req = cs_fall;
                TX_BOUNDARY: load_req = sclk_fall;
                default:     load_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= TX_IDLE;
            shift_reg   <= 8'h00;
            bit_cnt     <= 4'd0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            tx_abort    <= 1'b0;
        end else begin
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            tx_abort    <= 1'b0;
            if (cs_rise) begin
                state     <= TX_IDLE;
                bit_cnt   <= 4'd0;
                shift_reg <= 8'h00;
                tx_abort  <= mid_byte;
            end else if (load_req) begin
                shift_reg   <= load_take ? hold_reg : 8'h00;
                tx_underrun <= tx_enable && !hold_full;
                bit_cnt     <= 4'd0;
                state       <= TX_SHIFT;
            end else if (state == TX_SHIFT) begin
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        tx_done <= 1'b1;
                        state   <= TX_BOUNDARY;
                    end
                end else if (sclk_fall && mid_byte) begin
                    shift_reg <= {shift_reg[6:0], 1'b0};
                end
            end else if (state != TX_BOUNDARY && state != TX_IDLE) begin
                state   <= TX_IDLE;
                bit_cnt <= 4'd0;
            end
        end
    end

    // Accept and consume are mutually exclusive because one needs the holding
    // register empty and the other needs it full, so a load in the same cycle
    // as an accept sends fill and leaves the new byte for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= 8'h00;
            hold_full <= 1'b0;
        end else if (load_req && load_take) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= tx_data;
            hold_full <= 1'b1;
        end
    end

    assign cipo_oe = !cs_sync;
    assign CIPO    = cipo_oe && shift_reg[7];

endmodule

// File: tb/tb_spi_peripheral_tx.sv
// Testbench for spi_peripheral_tx: directed vector table, hand-written corner
// sequences and randomized frames checked against a byte-level reference model.
module tb_spi_peripheral_tx;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       cipo;
    logic       cipo_oe;
    logic       tx_enable = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_underrun;
    logic       tx_abort;

    int n_pass = 0;
    int n_total = 0;
    int cnt_done = 0;
    int cnt_under = 0;
    int cnt_abort = 0;

    typedef struct {
        string       name;
        bit          pre;
        logic [7:0]  pre_b;
        int          nbits;
        bit          trailing;
        int          offer_bit;
        logic [7:0]  offer_b;
        logic [31:0] exp_rx;
        int          exp_done;
        int          exp_un;
        int          exp_ab;
        bit          exp_ready;
    } vec_t;

    vec_t vecs[9];

    spi_peripheral_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SCLK        (sclk),
        .spi_cs_n    (cs_n),
        .CIPO        (cipo),
        .cipo_oe     (cipo_oe),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun),
        .tx_abort    (tx_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_done)     cnt_done  <= cnt_done + 1;
        if (tx_underrun) cnt_under <= cnt_under + 1;
        if (tx_abort)    cnt_abort <= cnt_abort + 1;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Offer one byte and hold tx_valid until it is taken or the bound expires.
    task automatic apply_stimulus(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic sclk_bit(inout logic [31:0] rx);
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        rx = {rx[30:0], cipo};
        sclk = 1'b1;
    endtask

    task automatic run_frame(input int nbits, input bit trailing, input int offer_bit,
                             input logic [7:0] offer_b, output logic [31:0] rx,
                             output int dn, output int un, output int ab, output bit offer_ok);
        int d0, u0, a0;
        bit ok;
        rx = 32'h0;
        offer_ok = 1'b0;
        @(negedge clk);
        d0 = cnt_done;
        u0 = cnt_under;
        a0 = cnt_abort;
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            sclk_bit(rx);
            if (i == offer_bit) begin
                apply_stimulus(offer_b, ok);
                offer_ok = ok;
            end
            repeat (HALF) @(negedge clk);
        end
        if (trailing) begin
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        dn = cnt_done - d0;
        un = cnt_under - u0;
        ab = cnt_abort - a0;
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] exp_rx;
        logic [7:0]  q[$];
        logic [7:0]  tmp;
        logic [7:0]  ob;
        logic [7:0]  m_hold;
        bit          m_full;
        bit          ok;
        bit          ook;
        bit          en;
        bit          trailing;
        int          dn, un, ab, d0, u0, a0;
        int          nbits, offer, m_un;

        vecs[0] = '{"a5",          1, 8'hA5, 8,  0, -1, 8'h00, 32'h000000A5, 1, 0, 0, 1};
        vecs[1] = '{"3c_c3",       1, 8'h3C, 16, 0,  3, 8'hC3, 32'h00003CC3, 2, 0, 0, 1};
        vecs[2] = '{"fill",        0, 8'h00, 8,  0, -1, 8'h00, 32'h00000000, 1, 1, 0, 1};
        vecs[3] = '{"abort",       1, 8'hFF, 3,  0, -1, 8'h00, 32'h00000007, 0, 0, 1, 1};
        vecs[4] = '{"after_abort", 1, 8'h96, 8,  0, -1, 8'h00, 32'h00000096, 1, 0, 0, 1};
        vecs[5] = '{"trail",       1, 8'h12, 8,  1, -1, 8'h00, 32'h00000012, 1, 1, 0, 1};
        vecs[6] = '{"trail_keep",  1, 8'h34, 8,  1,  3, 8'h56, 32'h00000034, 1, 0, 0, 1};
        vecs[7] = '{"preserve",    1, 8'h11, 8,  0,  3, 8'h22, 32'h00000011, 1, 0, 0, 0};
        vecs[8] = '{"preserved",   0, 8'h00, 8,  0, -1, 8'h00, 32'h00000022, 1, 0, 0, 1};

        repeat (3) @(negedge clk);
        #1;
        check_output("rst_cipo",     32'(cipo), 32'd0);
        check_output("rst_oe",       32'(cipo_oe), 32'd0);
        check_output("rst_done",     32'(tx_done), 32'd0);
        check_output("rst_underrun", 32'(tx_underrun), 32'd0);
        check_output("rst_abort",    32'(tx_abort), 32'd0);
        check_output("rst_ready",    32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        tx_enable = 1'b0;
        #1;
        check_output("ready_disabled", 32'(tx_ready), 32'd0);
        tx_enable = 1'b1;
        #1;
        check_output("ready_enabled", 32'(tx_ready), 32'd1);

        // CIPO latency from CS fall and output-enable release after CS rise.
        apply_stimulus(8'hC0, ok);
        check_output("lat_load", 32'(ok), 32'd1);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        check_output("lat_oe", 32'(cipo_oe), 32'd1);
        check_output("lat_cipo", 32'(cipo), 32'd1);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("lat_oe_off", 32'(cipo_oe), 32'd0);
        check_output("lat_cipo_off", 32'(cipo), 32'd0);
        repeat (4) @(negedge clk);
        check_output("lat_consumed", 32'(tx_ready), 32'd1);

        for (int v = 0; v < 9; v++) begin
            tx_enable = 1'b1;
            if (vecs[v].pre) begin
                apply_stimulus(vecs[v].pre_b, ok);
                check_output({vecs[v].name, "_preload"}, 32'(ok), 32'd1);
            end
            run_frame(vecs[v].nbits, vecs[v].trailing, vecs[v].offer_bit, vecs[v].offer_b,
                      rx, dn, un, ab, ook);
            check_output({vecs[v].name, "_rx"}, rx, vecs[v].exp_rx);
            check_output({vecs[v].name, "_done"}, 32'(dn), 32'(vecs[v].exp_done));
            check_output({vecs[v].name, "_underrun"}, 32'(un), 32'(vecs[v].exp_un));
            check_output({vecs[v].name, "_abort"}, 32'(ab), 32'(vecs[v].exp_ab));
            check_output({vecs[v].name, "_ready"}, 32'(tx_ready), 32'(vecs[v].exp_ready));
            if (vecs[v].offer_bit >= 0)
                check_output({vecs[v].name, "_offer"}, 32'(ook), 32'd1);
        end

        // Disabled transmitter: fill is sent, nothing is consumed, no underrun.
        @(negedge clk);
        tx_enable = 1'b0;
        tx_data   = 8'h81;
        tx_valid  = 1'b1;
        #1;
        check_output("dis_ready", 32'(tx_ready), 32'd0);
        run_frame(8, 0, -1, 8'h00, rx, dn, un, ab, ook);
        check_output("dis_rx", rx, 32'h0);
        check_output("dis_done", 32'(dn), 32'd1);
        check_output("dis_underrun", 32'(un), 32'd0);
        tx_valid  = 1'b0;
        tx_enable = 1'b1;
        #1;
        check_output("dis_not_consumed", 32'(tx_ready), 32'd1);

        // Reset in the middle of a byte discards everything silently.
        apply_stimulus(8'h5A, ok);
        check_output("rstmid_load", 32'(ok), 32'd1);
        @(negedge clk);
        cs_n = 1'b0;
        rx = 32'h0;
        for (int i = 0; i < 4; i++) begin
            sclk_bit(rx);
            repeat (HALF) @(negedge clk);
        end
        check_output("rstmid_bits", rx, 32'h5);
        rst_n = 1'b0;
        #1;
        check_output("rstmid_cipo", 32'(cipo), 32'd0);
        check_output("rstmid_oe", 32'(cipo_oe), 32'd0);
        check_output("rstmid_pulses", 32'({tx_done, tx_underrun, tx_abort}), 32'd0);
        check_output("rstmid_ready", 32'(tx_ready), 32'd1);
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        d0 = cnt_done;
        u0 = cnt_under;
        a0 = cnt_abort;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_output("rstmid_no_pulse", 32'((cnt_done - d0) + (cnt_under - u0) + (cnt_abort - a0)), 32'd0);
        run_frame(8, 0, -1, 8'h00, rx, dn, un, ab, ook);
        check_output("rstmid_rx", rx, 32'h0);
        check_output("rstmid_underrun", 32'(un), 32'd1);
        check_output("rstmid_done", 32'(dn), 32'd1);

        // Randomized frames against a byte-level model of the holding register.
        m_full = 1'b0;
        m_hold = 8'h00;
        for (int f = 0; f < 20; f++) begin
            en        = ($urandom_range(0, 7) != 0);
            tx_enable = en;
            nbits     = $urandom_range(1, 24);
            trailing  = 1'($urandom_range(0, 1));
            if (en && !m_full && $urandom_range(0, 1) == 1) begin
                tmp = 8'($urandom);
                apply_stimulus(tmp, ok);
                check_output("rnd_preload", 32'(ok), 32'd1);
                m_full = 1'b1;
                m_hold = tmp;
            end
            q.delete();
            m_un  = 0;
            offer = -1;
            ob    = 8'h00;
            for (int k = 0; k < nbits || (k == nbits && nbits % 8 == 0 && trailing); k += 8) begin
                if (en && m_full) begin
                    q.push_back(m_hold);
                    m_full = 1'b0;
                end else begin
                    if (en) m_un++;
                    q.push_back(8'h00);
                end
                if (k == 0 && en && !m_full && nbits > 3 && $urandom_range(0, 1) == 1) begin
                    offer  = 3;
                    ob     = 8'($urandom);
                    m_full = 1'b1;
                    m_hold = ob;
                end
            end
            exp_rx = 32'h0;
            for (int i = 0; i < nbits; i++) begin
                tmp    = q[i / 8];
                exp_rx = {exp_rx[30:0], tmp[7 - (i % 8)]};
            end
            run_frame(nbits, trailing, offer, ob, rx, dn, un, ab, ook);
            check_output("rnd_rx", rx, exp_rx);
            check_output("rnd_done", 32'(dn), 32'(nbits / 8));
            check_output("rnd_underrun", 32'(un), 32'(m_un));
            check_output("rnd_abort", 32'(ab), 32'((nbits % 8) != 0));
            check_output("rnd_ready", 32'(tx_ready), 32'(en && !m_full));
            if (offer >= 0) check_output("rnd_offer", 32'(ook), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_peripheral_tx.md
SPI_PERIPHERAL_TX -- requirements
Module: spi_peripheral_tx

Interface
REQ-001 clk  input  1  system clock; all logic on its rising edge; SHALL run at >= 8x SCLK frequency.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SCLK  input  1  SPI clock from controller, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-004 spi_cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-005 CIPO  output  1  serial data to controller, MSB first.
REQ-006 cipo_oe  output  1  CIPO output enable; 1 only while synchronized chip select is active.
REQ-007 tx_enable  input  1  1 = consume and transmit buffered bytes; 0 = transmit fill 0x00 without consuming.
REQ-008 tx_data  input  8  byte to transmit.
REQ-009 tx_valid  input  1  tx_data valid.
REQ-010 tx_ready  output  1  holding register empty; a byte is accepted on any clk edge where tx_valid && tx_ready.
REQ-011 tx_done  output  1  one-cycle pulse: a byte finished (8th SCLK rising edge).
REQ-012 tx_underrun  output  1  one-cycle pulse: byte boundary reached with holding register empty; 0x00 sent instead.
REQ-013 tx_abort  output  1  one-cycle pulse: chip select deasserted after 1-7 bits of a byte.

Function
REQ-014 SCLK and spi_cs_n SHALL each pass a 2-flop synchronizer; edges (sclk_rise, sclk_fall, cs_fall, cs_rise) SHALL be detected from the synchronized value and its one-cycle-delayed copy.
REQ-015 Storage: hold_reg[7:0] + hold_full flag, shift_reg[7:0], bit_cnt[3:0].
REQ-016 tx_ready = !hold_full && tx_enable; on accept, hold_reg <= tx_data, hold_full <= 1.
REQ-017 "Load" operation: if tx_enable && hold_full then shift_reg <= hold_reg and hold_full <= 0; else if tx_enable then shift_reg <= 0x00 and tx_underrun pulses; else shift_reg <= 0x00 with no pulse.
REQ-018 Simultaneous accept and load in one cycle: load SHALL see the pre-accept hold_full (0), so fill 0x00 and tx_underrun pulse; the accepted byte SHALL stay in hold_reg for the next boundary.
REQ-019 FSM states: TX_IDLE, TX_SHIFT, TX_BOUNDARY; reset state TX_IDLE.
REQ-020 TX_IDLE: on cs_fall perform load, bit_cnt <= 0, go TX_SHIFT.
REQ-021 TX_SHIFT: sclk_rise -> bit_cnt + 1; sclk_fall with bit_cnt in 1..7 -> shift_reg <= {shift_reg[6:0], 1'b0}; sclk_rise raising bit_cnt to 8 -> tx_done pulse the following cycle, go TX_BOUNDARY.
REQ-022 TX_BOUNDARY: on sclk_fall perform load, bit_cnt <= 0, go TX_SHIFT (back-to-back bytes within one chip-select frame).
REQ-023 Any state: cs_rise -> go TX_IDLE, bit_cnt <= 0, shift_reg <= 0; tx_abort pulses if bit_cnt was 1..7; hold_reg/hold_full SHALL be preserved.
REQ-024 cs_rise in the same cycle as an SCLK edge: cs_rise SHALL take priority; the edge is ignored.
REQ-025 CIPO = shift_reg[7] when cipo_oe = 1, else 0; cipo_oe = inverted synchronized spi_cs_n.
REQ-026 Latency: CIPO valid <= 4 clk cycles after spi_cs_n falls, and <= 4 clk cycles after an SCLK falling edge; controller SHALL allow >= 4 clk from CS fall to first SCLK rise.
REQ-027 bit_cnt SHALL never exceed 8; extra SCLK rising edges in TX_BOUNDARY SHALL be ignored.
REQ-028 Pulse outputs SHALL be registered, high for exactly one clk cycle.

Reset
REQ-029 While rst_n = 0: state TX_IDLE; CIPO, cipo_oe, tx_done, tx_underrun, tx_abort = 0; hold_full = 0; shift_reg, hold_reg, bit_cnt = 0; synchronizers SHALL reset to spi_cs_n = 1, SCLK = 0.
REQ-030 After reset release: tx_ready = tx_enable; a reset asserted mid-frame SHALL discard all data without any pulse.

Verification
REQ-031 Load 0xA5, CS low, 8 SCLK pulses -> controller samples 1,0,1,0,0,1,0,1; one tx_done; tx_ready returns 1 after load.
REQ-032 Load 0x3C, CS low, 16 SCLK pulses, 0xC3 offered during first byte -> 0x3C then 0xC3 received; two tx_done; no tx_underrun.
REQ-033 CS low with holding register empty, 8 SCLK pulses -> 0x00 received; one tx_underrun at CS fall; one tx_done.
REQ-034 Load 0xFF, CS low, 3 SCLK pulses, CS high -> one tx_abort; no tx_done; cipo_oe = 0 within 3 clk; next frame sends fill/next byte from bit 7.
REQ-035 tx_enable = 0, tx_valid held high with 0x81, CS frame of 8 pulses -> tx_ready = 0, 0x00 received, no tx_underrun, 0x81 not consumed.
REQ-036 rst_n pulsed low after 4 bits of 0x5A -> all outputs 0 immediately; following frame with no load yields 0x00 and tx_underrun.
